seg_display_scanner: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment display driver. It supersedes the fixed 4:1 combinational segment mux.
- A refresh divider steps a one-hot anode scan across NUM_DIGITS digits.
- Per-digit decimal point, per-digit enable (blanking), anti-ghosting blank gap, and frame-coherent shadow latching of inputs, so counter updates never tear mid-frame.
- Sits between the clock/time counters and the board's seven-segment pins.

---
 rtl/seg_display_scanner_pkg.sv | 26 ++
 rtl/seg_display_scanner_scan_counter.sv | 64 ++++++
 rtl/seg_display_scanner.sv | 130 +++++++++++++
 tb/tb_seg_display_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
//   Shared constants for the seven-segment display scanner.
//   - SEG_W   : number of segment lines (a..g)
//   - SEG_OFF : active-high "all segments dark" pattern
//   - HEX_SEG : hex digit to segment table, bit order g..a, 1 = lit
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Convenience lookup for upstream counters that hold BCD/hex nibbles.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/seg_display_scanner_scan_counter.sv
// -----------------------------------------------------------------------------
// seg_scan_counter
//   Refresh divider and digit index for the display scan. div_cnt runs
//   0..REFRESH_DIV-1; on its wrap the digit index advances, wrapping from
//   NUM_DIGITS-1 back to 0.
//   Ports:
//     clk_i, rst_ni    : clock, asynchronous active-low reset
//     div_cnt_o        : position inside the current digit slot
//     digit_idx_o      : digit currently being scanned
//     frame_start_o    : state (digit 0, div 0) - shadow load point
//     frame_end_o      : state (last digit, last div) - scan wrap point
// -----------------------------------------------------------------------------
module seg_scan_counter #(
    parameter  int NUM_DIGITS  = 4,
    parameter  int REFRESH_DIV = 100000,
    localparam int DIV_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
    localparam int IDX_W       = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [DIV_W-1:0] div_cnt_o,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             frame_start_o,
    output logic             frame_end_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic             div_wrap;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        div_wrap    = (div_cnt_q == DIV_LAST);
        div_cnt_d   = div_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (div_wrap) begin
            div_cnt_d   = '0;
            // Explicit wrap: NUM_DIGITS need not be a power of two.
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // from the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign div_cnt_o     = div_cnt_q;
    assign digit_idx_o   = digit_idx_q;
    assign frame_start_o = (digit_idx_q == '0)      && (div_cnt_q == '0);
    assign frame_end_o   = (digit_idx_q == IDX_LAST) && div_wrap;

endmodule

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Time-multiplexed N-digit seven-segment driver with frame-coherent shadow
//   latching, per-digit blanking/decimal point and an anti-ghosting blank gap
//   at the start of every digit slot. All pin outputs are registered.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     digit_segs  : 7 bits per digit, digit i at [7i+6:7i], g..a, 1 = lit
//     digit_dp    : decimal point per digit, 1 = lit
//     digit_en    : 1 = digit shown, 0 = digit blanked (slot still consumed)
//     seg, dp     : segment / decimal point pins, polarity SEG_ACTIVE_LOW
//     an          : one-hot anode pins, polarity AN_ACTIVE_LOW
//     frame_tick  : one-cycle pulse as the scan wraps back to digit 0
// -----------------------------------------------------------------------------
module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W*NUM_DIGITS-1:0] digit_segs,
    input  logic [NUM_DIGITS-1:0]       digit_dp,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
    // XOR masks that turn active-high internal values into pin levels; they
    // are also the inactive pin levels driven during reset.
    localparam logic [NUM_DIGITS-1:0] AN_INV    = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      SEG_INV   = {SEG_W{SEG_ACTIVE_LOW}};

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             frame_start;
    logic             frame_end;

    seg_scan_counter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan_counter (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .div_cnt_o     (div_cnt),
        .digit_idx_o   (digit_idx),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    logic [SEG_W*NUM_DIGITS-1:0] shadow_segs_q, shadow_segs_d;
    logic [NUM_DIGITS-1:0]       shadow_dp_q,   shadow_dp_d;
    logic [NUM_DIGITS-1:0]       shadow_en_q,   shadow_en_d;

    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q,  dp_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [SEG_W-1:0]      cur_segs;
    logic                  blank;

    always_comb begin
        // Inputs are sampled only at the frame boundary so a counter update
        // can never tear across digits within one frame.
        shadow_segs_d = shadow_segs_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_en_d   = shadow_en_q;
        if (frame_start) begin
            shadow_segs_d = digit_segs;
            shadow_dp_d   = digit_dp;
            shadow_en_d   = digit_en;
        end

        // Outputs are built from the pre-update shadow. The load cycle sits at
        // div_cnt == 0, which is always inside the blank gap, so stale shadow
        // contents never reach the pins.
        cur_segs = shadow_segs_q[int'(digit_idx)*SEG_W +: SEG_W];
        blank    = (div_cnt < BLANK_END) || !shadow_en_q[digit_idx];

        an_d  = blank ? '0 : (NUM_DIGITS'(1) << digit_idx);
        seg_d = blank ? SEG_OFF : cur_segs;
        dp_d  = !blank && shadow_dp_q[digit_idx];

        an_d  = an_d  ^ AN_INV;
        seg_d = seg_d ^ SEG_INV;
        dp_d  = dp_d  ^ SEG_ACTIVE_LOW;

        // Registered wrap flag lands in the same cycle as the boundary state.
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow bank is reset too (it is plain flops, not a RAM),
            // keeping the display dark and deterministic until the first load.
            shadow_segs_q <= '0;
            shadow_dp_q   <= '0;
            shadow_en_q   <= '0;
            an_q          <= AN_INV;
            seg_q         <= SEG_INV;
            dp_q          <= SEG_ACTIVE_LOW;
            frame_tick_q  <= 1'b0;
        end else begin
            shadow_segs_q <= shadow_segs_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_en_q   <= shadow_en_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//   Scoreboard bench: the stimulus process pushes the expected pin state for
//   every cycle it drives; a monitor on the falling edge pops and compares.
//   A second instance with active-high polarity covers the inverted pins.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    typedef struct packed {
        logic [27:0] segs;
        logic [3:0]  dp;
        logic [3:0]  en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [27:0] digit_segs;
    logic [3:0]  digit_dp, digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    logic [27:0] digit_segs2;
    logic [3:0]  digit_dp2, digit_en2;
    logic [6:0]  seg2;
    logic        dp2;
    logic [3:0]  an2;
    logic        frame_tick2;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .digit_segs(digit_segs), .digit_dp(digit_dp), .digit_en(digit_en),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    seg_display_scanner #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .digit_segs(digit_segs2), .digit_dp(digit_dp2), .digit_en(digit_en2),
        .seg(seg2), .dp(dp2), .an(an2), .frame_tick(frame_tick2)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[4];
    vec_t glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input vec_t v);
        digit_segs = v.segs;
        digit_dp   = v.dp;
        digit_en   = v.en;
    endtask

    // Expected pins after edge c (c = 1 is the first edge after reset release):
    // the output reflects scan state s = c-1, shown with vector v.
    function automatic exp_t expect_at(input int c, input vec_t v);
        exp_t       e;
        int         s     = c - 1;
        int         idx   = (s / DIV) % N;
        int         pos   = s % DIV;
        logic [3:0] onehot = 4'b0001 << idx;
        logic [6:0] pat    = v.segs[idx*7 +: 7];
        logic       blank  = (pos < BLK) || !v.en[idx];
        e.an  = blank ? 4'hF  : ~onehot;
        e.seg = blank ? 7'h7F : ~pat;
        e.dp  = blank ? 1'b1  : ~v.dp[idx];
        e.ft  = ((s % (N*DIV)) == N*DIV - 1);
        return e;
    endfunction

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_an",  an,         e.an);
                check("sb_seg", seg,        e.seg);
                check("sb_dp",  dp,         e.dp);
                check("sb_ft",  frame_tick, e.ft);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{segs: {7'h06, 7'h5B, 7'h4F, 7'h66}, dp: 4'b0000, en: 4'b1111};
        vecs[1] = '{segs: {7'h3F, 7'h7D, 7'h07, 7'h7F}, dp: 4'b0100, en: 4'b1111};
        vecs[2] = '{segs: {7'h06, 7'h5B, 7'h4F, 7'h66}, dp: 4'b0010, en: 4'b1011};
        vecs[3] = '{segs: {7'h71, 7'h79, 7'h5E, 7'h39}, dp: 4'b1000, en: 4'b1111};
        glitch  = '{segs: '0, dp: 4'hF, en: 4'h0};

        apply(vecs[0]);
        digit_segs2 = {21'h0, 7'h3F};
        digit_dp2   = 4'b0000;
        digit_en2   = 4'b0001;

        // Reset state, both polarities.
        #12;
        check("rst_an",   an,         4'hF);
        check("rst_seg",  seg,        7'h7F);
        check("rst_dp",   dp,         1'b1);
        check("rst_ft",   frame_tick, 1'b0);
        check("rst_an2",  an2,        4'h0);
        check("rst_seg2", seg2,       7'h00);
        check("rst_dp2",  dp2,        1'b0);
        check("rst_ft2",  frame_tick2, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Four frames: A, B (changed mid-frame 0), C (blanked digit 2, dp on
        // digit 1), D; then reset lands in digit 2's slot at position 5.
        for (int c = 1; c <= 117; c++) begin
            @(posedge clk);
            #1;
            sb_q.push_back(expect_at(c, vecs[(c - 1) / (N*DIV)]));
            case (c)
                2:  check("still_blank_an", an, 4'hF);
                3: begin
                    check("first_lit_an",   an,   4'b1110);
                    check("first_lit_seg",  seg,  7'h19);
                    check("hi_lit_an",      an2,  4'b0001);
                    check("hi_lit_seg",     seg2, 7'h3F);
                end
                11: check("d1_seg",         seg,        7'h30);
                12: apply(vecs[1]);
                19: check("no_tear_seg",    seg,        7'h24);
                20: apply(glitch);
                21: apply(vecs[1]);
                31: check("ft_low_before",  frame_tick, 1'b0);
                32: check("ft_first_pulse", frame_tick, 1'b1);
                35: check("new_frame_seg",  seg,        7'h00);
                40: apply(vecs[2]);
                70: apply(vecs[3]);
                75: check("dp_digit1",      dp,         1'b0);
                83: begin
                    check("dis_d2_an",  an,  4'hF);
                    check("dis_d2_seg", seg, 7'h7F);
                end
                default: ;
            endcase
        end

        // Async reset mid-slot: outputs drop to reset values without a clock.
        @(negedge clk);
        check("pre_reset_an", an, 4'b1011);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_an",  an,   4'hF);
        check("async_rst_seg", seg,  7'h7F);
        check("async_rst_dp",  dp,   1'b1);
        check("async_rst_an2", an2,  4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_an", an, 4'hF);

        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            sb_q.push_back(expect_at(c, vecs[3]));
            if (c == 3) begin
                check("restart_an",  an,  4'b1110);
                check("restart_seg", seg, 7'h46);
            end
        end

        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
